// File: rtl/sr_latch_bank_sched.sv
// ============================================================================
// Module      : sr_latch_bank_sched
// Description : Round-robin scheduler that drives non-overlapping set/reset
//               pulses into a bank of NOR SR latches and verifies readback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_latch_bank_sched #(
  parameter int N       = 4,
  parameter int IDX_W   = 3,
  parameter int PULSE_W = 2,
  parameter int GAP     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             op_a,
  input  logic [IDX_W-1:0] idx_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic             op_b,
  input  logic [IDX_W-1:0] idx_b,
  output logic             ack_b,
  input  logic [N-1:0]     q_fb,
  output logic [N-1:0]     s,
  output logic [N-1:0]     r,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             done_src
);

  localparam int c_MAXC  = (PULSE_W > GAP) ? PULSE_W : GAP;
  localparam int c_CNT_W = $clog2(c_MAXC + 1);
  localparam int c_SPAN  = 1 << IDX_W;
  localparam logic [c_CNT_W-1:0] c_PULSE_LAST = c_CNT_W'(PULSE_W - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [IDX_W:0]     c_N          = (IDX_W + 1)'(N);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PULSE   = 2'd1,
    S_RECOVER = 2'd2,
    S_CHECK   = 2'd3
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_ptr;
  logic               r_op;
  logic [IDX_W-1:0]   r_idx;
  logic               r_src;

  logic               w_grant_a;
  logic               w_grant_b;
  logic               w_gnt_op;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_gnt_bad;
  logic [c_SPAN-1:0]  w_q_ext;
  logic [c_SPAN-1:0]  w_gnt_hot;

  // r_ptr = 0 favours A on a tie, 1 favours B
  assign w_grant_a = req_a & (~req_b | ~r_ptr);
  assign w_grant_b = req_b & (~req_a |  r_ptr);
  assign w_gnt_op  = w_grant_b ? op_b  : op_a;
  assign w_gnt_idx = w_grant_b ? idx_b : idx_a;
  assign w_gnt_bad = {1'b0, w_gnt_idx} >= c_N;
  // Widened copies let any encodable index select safely without range checks
  assign w_q_ext   = c_SPAN'(q_fb);
  assign w_gnt_hot = {{(c_SPAN-1){1'b0}}, 1'b1} << w_gnt_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ptr    <= 1'b0;
      r_op     <= 1'b0;
      r_idx    <= '0;
      r_src    <= 1'b0;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      s        <= '0;
      r        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      done_src <= 1'b0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_a || w_grant_b) begin
            ack_a <= w_grant_a;
            ack_b <= w_grant_b;
            busy  <= 1'b1;
            r_ptr <= w_grant_a;
            r_src <= w_grant_b;
            r_op  <= w_gnt_op;
            r_idx <= w_gnt_idx;
            if (w_gnt_bad || (w_q_ext[w_gnt_idx] == w_gnt_op)) begin
              r_state  <= S_CHECK;
              done     <= 1'b1;
              err      <= w_gnt_bad;
              done_src <= w_grant_b;
            end else begin
              r_state <= S_PULSE;
              r_cnt   <= c_PULSE_LAST;
              s       <= w_gnt_op ? w_gnt_hot[N-1:0] : '0;
              r       <= w_gnt_op ? '0 : w_gnt_hot[N-1:0];
            end
          end
        end
        S_PULSE: begin
          if (r_cnt == '0) begin
            s <= '0;
            r <= '0;
            if (GAP > 0) begin
              r_state <= S_RECOVER;
              r_cnt   <= c_GAP_LAST;
            end else begin
              r_state  <= S_CHECK;
              done     <= 1'b1;
              err      <= (w_q_ext[r_idx] != r_op);
              done_src <= r_src;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RECOVER: begin
          if (r_cnt == '0) begin
            r_state  <= S_CHECK;
            done     <= 1'b1;
            err      <= (w_q_ext[r_idx] != r_op);
            done_src <= r_src;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_CHECK: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sr_latch_bank_sched.sv
// ============================================================================
// Module      : tb_sr_latch_bank_sched
// Description : Self-checking bench for sr_latch_bank_sched with a NOR latch
//               bank model, directed vectors and a transaction-level reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sr_latch_bank_sched;

  localparam int N = 4, IDX_W = 3, PULSE_W = 2, GAP = 1;
  localparam int c_LAT_PULSE = PULSE_W + GAP + 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_a = 1'b0, op_a = 1'b0, req_b = 1'b0, op_b = 1'b0;
  logic [IDX_W-1:0] idx_a = '0, idx_b = '0;
  logic ack_a, ack_b, busy, done, err, done_src;
  logic [N-1:0] s, r, q_fb;
  logic [N-1:0] latch_q = '0;
  logic [N-1:0] stuck_mask = '0, stuck_val = '0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  // Cross-coupled NOR bank: reacts to s/r immediately; stuck bits override q
  always @(s or r) begin
    for (int i = 0; i < N; i++) begin
      if (s[i]) latch_q[i] = 1'b1;
      else if (r[i]) latch_q[i] = 1'b0;
    end
  end
  assign q_fb = (latch_q & ~stuck_mask) | (stuck_val & stuck_mask);

  sr_latch_bank_sched #(.N(N), .IDX_W(IDX_W), .PULSE_W(PULSE_W), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .op_a(op_a), .idx_a(idx_a), .ack_a(ack_a),
    .req_b(req_b), .op_b(op_b), .idx_b(idx_b), .ack_b(ack_b),
    .q_fb(q_fb), .s(s), .r(r), .busy(busy), .done(done), .err(err),
    .done_src(done_src)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input logic src, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((src ? ack_b : ack_a) !== 1'b1) && n < 30);
    if ((src ? ack_b : ack_a) !== 1'b1) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_any_ack(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack_a !== 1'b1 && ack_b !== 1'b1 && n < 30);
    if (ack_a !== 1'b1 && ack_b !== 1'b1) chk("any_ack_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic           src;
    logic           op;
    logic [IDX_W-1:0] idx;
    logic [N-1:0]   smask;
    logic [N-1:0]   sval;
    int             lat;
    logic           eerr;
    logic [N-1:0]   es;
    logic [N-1:0]   er;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int n, dcyc;
    logic derr, dsrc;
    dcyc = 0; derr = 1'b0; dsrc = 1'b0;
    stuck_mask = v.smask;
    stuck_val  = v.sval;
    @(negedge clk);
    if (v.src) begin req_b = 1'b1; op_b = v.op; idx_b = v.idx; end
    else       begin req_a = 1'b1; op_a = v.op; idx_a = v.idx; end
    wait_ack(v.src, n);
    chk("vec_other_ack", v.src ? ack_a : ack_b, 32'd0);
    // Withdraw and scramble the request: captured values must not follow
    req_a = 1'b0; req_b = 1'b0;
    op_a = ~v.op; op_b = ~v.op; idx_a = ~v.idx; idx_b = ~v.idx;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= PULSE_W) begin
        chk("vec_s", s, v.es);
        chk("vec_r", r, v.er);
      end else if (k == PULSE_W + 1) begin
        chk("vec_gap_sr", s | r, 32'd0);
      end
      if (done === 1'b1 && dcyc == 0) begin
        dcyc = k; derr = err; dsrc = done_src;
      end
      if (k == v.lat + 1) chk("vec_busy_low", busy, 32'd0);
    end
    chk("vec_done_cycle", dcyc, v.lat);
    chk("vec_err", derr, v.eerr);
    chk("vec_src", dsrc, v.src);
    stuck_mask = '0;
    stuck_val  = '0;
  endtask

  // Transaction-level reference for the randomized phase
  logic       m_active, m_ptr, m_src, m_op, m_pulse, m_err;
  logic [IDX_W-1:0] m_idx;
  int         m_cnt, m_lat;
  logic [7:0] mq;
  logic       e_ack_a, e_ack_b, e_busy, e_done;
  logic [N-1:0] e_s, e_r;

  task automatic model_step();
    logic ga, gb, cur, isbad;
    logic [7:0] sm8, sv8;
    sm8 = 8'(stuck_mask);
    sv8 = 8'(stuck_val);
    e_ack_a = 1'b0;
    e_ack_b = 1'b0;
    if (!m_active) begin
      ga = req_a && (!req_b || !m_ptr);
      gb = req_b && (!req_a || m_ptr);
      if (ga || gb) begin
        e_ack_a = ga; e_ack_b = gb;
        m_src = gb; m_ptr = ga;
        m_op  = gb ? op_b : op_a;
        m_idx = gb ? idx_b : idx_a;
        isbad = (int'(m_idx) >= N);
        cur   = sm8[m_idx] ? sv8[m_idx] : mq[m_idx];
        m_pulse = !isbad && (cur != m_op);
        m_lat = m_pulse ? c_LAT_PULSE : 1;
        if (isbad) m_err = 1'b1;
        else if (!m_pulse) m_err = 1'b0;
        else m_err = sm8[m_idx] && (sv8[m_idx] != m_op);
        if (!isbad && !sm8[m_idx]) mq[m_idx] = m_op;
        m_active = 1'b1;
        m_cnt = 0;
      end
    end else begin
      m_cnt++;
      if (m_cnt >= m_lat) m_active = 1'b0;
    end
    e_busy = m_active;
    e_done = m_active && (m_cnt == m_lat - 1);
    e_s = '0;
    e_r = '0;
    if (m_active && m_pulse && m_cnt < PULSE_W) begin
      if (m_op) e_s = 4'b0001 << m_idx;
      else      e_r = 4'b0001 << m_idx;
    end
  endtask

  vec_t vt[6];

  initial begin
    int n, dcnt;
    vt[0] = '{1'b0, 1'b1, 3'd2, 4'b0000, 4'b0000, c_LAT_PULSE, 1'b0, 4'b0100, 4'b0000};
    vt[1] = '{1'b1, 1'b0, 3'd1, 4'b0010, 4'b0010, c_LAT_PULSE, 1'b1, 4'b0000, 4'b0010};
    vt[2] = '{1'b0, 1'b1, 3'd3, 4'b1000, 4'b1000, 1,           1'b0, 4'b0000, 4'b0000};
    vt[3] = '{1'b0, 1'b1, 3'd5, 4'b0000, 4'b0000, 1,           1'b1, 4'b0000, 4'b0000};
    vt[4] = '{1'b1, 1'b1, 3'd0, 4'b0000, 4'b0000, c_LAT_PULSE, 1'b0, 4'b0001, 4'b0000};
    vt[5] = '{1'b0, 1'b0, 3'd0, 4'b0000, 4'b0000, c_LAT_PULSE, 1'b0, 4'b0000, 4'b0001};

    @(negedge clk);
    chk("rst_s", s, 32'd0);
    chk("rst_r", r, 32'd0);
    chk("rst_ack", {ack_a, ack_b}, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_err", err, 32'd0);
    chk("rst_src", done_src, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // Simultaneous requests: A wins first, B wins the next tie
    do_reset();
    @(negedge clk);
    req_a = 1'b1; op_a = 1'b1; idx_a = 3'd0;
    req_b = 1'b1; op_b = 1'b0; idx_b = 3'd1;
    wait_any_ack(n);
    chk("pair1_ack_a", ack_a, 32'd1);
    chk("pair1_ack_b", ack_b, 32'd0);
    op_a = 1'b0; idx_a = 3'd2;
    wait_any_ack(n);
    chk("pair2_ack_b", ack_b, 32'd1);
    chk("pair2_ack_a", ack_a, 32'd0);
    chk("pair2_spacing", n, c_LAT_PULSE + 1);
    req_b = 1'b0;
    wait_ack(1'b0, n);
    chk("pair3_ack_a", ack_a, 32'd1);
    req_a = 1'b0;
    repeat (8) @(negedge clk);

    // Reset during the second pulse cycle of an A operation
    req_a = 1'b1; op_a = 1'b1; idx_a = 3'd3;
    wait_ack(1'b0, n);
    req_a = 1'b0;
    chk("abort_s_c1", s, 32'h8);
    @(posedge clk);
    #2;
    chk("abort_s_c2", s, 32'h8);
    rst_n = 1'b0;
    #1;
    chk("abort_s_drop", s, 32'd0);
    chk("abort_r_drop", r, 32'd0);
    chk("abort_busy_drop", busy, 32'd0);
    chk("abort_done_drop", done, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dcnt++;
    end
    chk("abort_no_done", dcnt, 32'd0);
    req_a = 1'b1; op_a = 1'b0; idx_a = 3'd3;
    req_b = 1'b1; op_b = 1'b1; idx_b = 3'd1;
    wait_any_ack(n);
    chk("post_rst_ack_a", ack_a, 32'd1);
    req_a = 1'b0;
    dcnt = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      if (done === 1'b1 && dcnt == 0) begin
        dcnt = k;
        chk("post_rst_err", err, 32'd0);
        chk("post_rst_src", done_src, 32'd0);
      end
    end
    chk("post_rst_done_cycle", dcnt, c_LAT_PULSE);
    wait_ack(1'b1, n);
    req_b = 1'b0;
    repeat (8) @(negedge clk);

    // Randomized traffic against the reference model
    do_reset();
    m_active = 1'b0; m_ptr = 1'b0; m_cnt = 0; m_lat = 1;
    m_src = 1'b0; m_op = 1'b0; m_pulse = 1'b0; m_err = 1'b0; m_idx = '0;
    mq = 8'(latch_q);
    stuck_mask = 4'b0100;
    stuck_val  = 4'b0100;
    for (int cyc = 0; cyc < 520; cyc++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("rnd_ack_a", ack_a, e_ack_a);
      chk("rnd_ack_b", ack_b, e_ack_b);
      chk("rnd_busy", busy, e_busy);
      chk("rnd_done", done, e_done);
      chk("rnd_s", s, e_s);
      chk("rnd_r", r, e_r);
      if (e_done) begin
        chk("rnd_err", err, m_err);
        chk("rnd_src", done_src, m_src);
      end
      if (e_ack_a) req_a = 1'b0;
      if (e_ack_b) req_b = 1'b0;
      if (cyc < 500) begin
        if (!req_a && $urandom_range(0, 2) == 0) begin
          req_a = 1'b1; op_a = 1'($urandom); idx_a = 3'($urandom_range(0, 5));
        end
        if (!req_b && $urandom_range(0, 2) == 0) begin
          req_b = 1'b1; op_b = 1'($urandom); idx_b = 3'($urandom_range(0, 5));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
